v_state_arb: RTL and testbench
==============================

V_STATE_ARB -- requirements
Module: v_state_arb

Interface
REQ-001 Parameter CONTEXT_N, default 128, number of state-table entries (power of two, >=2).
REQ-002 Parameter W, default 32, state-table word width in bits.
REQ-003 Parameter STARVE_N, default 4, consecutive query denials before forced query grant (1..15).
REQ-004 Localparam ADDR_W = $clog2(CONTEXT_N).
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 i_upd_ren  in  1  update-pipe read request.
REQ-008 i_upd_raddr  in  ADDR_W  update-pipe read address.
REQ-009 o_upd_rgnt  out  1  update read granted this cycle.
REQ-010 o_upd_rvld / o_upd_rdata  out  1 / W  update read response.
REQ-011 i_qry_ren / i_qry_raddr  in  1 / ADDR_W  query-pipe read request and address.
REQ-012 o_qry_rgnt  out  1  query read granted this cycle.
REQ-013 o_qry_rvld / o_qry_rdata  out  1 / W  query read response.
REQ-014 i_upd_wen / i_upd_waddr / i_upd_wdata  in  1 / ADDR_W / W  update-pipe write port.
REQ-015 o_sram_ren / o_sram_raddr  out  1 / ADDR_W  SRAM read port.
REQ-016 i_sram_rdata  in  W  SRAM read data, valid one cycle after o_sram_ren.
REQ-017 o_sram_wen / o_sram_waddr / o_sram_wdata  out  1 / ADDR_W / W  SRAM write port.
REQ-018 o_init_done  out  1  high once table initialisation complete.

Function
REQ-019 FSM states INIT, RUN; INIT entered on reset; INIT->RUN after final init write; RUN has no exit other than reset.
REQ-020 INIT: one SRAM write per cycle, data all-zero, address counter 0..CONTEXT_N-1; CONTEXT_N cycles total.
REQ-021 INIT: o_upd_rgnt, o_qry_rgnt, o_sram_ren = 0; i_upd_wen ignored.
REQ-022 o_init_done = 1 from first RUN cycle; registered output.
REQ-023 RUN: o_sram_wen/waddr/wdata = i_upd_wen/waddr/wdata combinationally.
REQ-024 RUN: one read grant per cycle max; o_sram_ren = o_upd_rgnt | o_qry_rgnt; o_sram_raddr = granted requester's address.
REQ-025 Default priority: update over query; query granted only when i_upd_ren = 0 (subject to REQ-032).
REQ-026 Denied requester holds request and address until granted; arbiter keeps no request queue.
REQ-027 Response: o_x_rvld asserts exactly one cycle after o_x_rgnt; o_x_rdata = i_sram_rdata; other requester's rvld = 0.
REQ-028 Bypass: if granted read address equals i_upd_waddr with i_upd_wen = 1 same cycle, response data = registered i_upd_wdata instead of i_sram_rdata.
REQ-029 o_x_rdata undefined-safe: driven 0 when o_x_rvld = 0.
REQ-030 Write during INIT from upstream is a protocol violation; bench asserts i_upd_wen = 0 while o_init_done = 0.

Reset
REQ-031 On rst: FSM = INIT, init counter = 0, o_init_done = 0, o_upd_rvld = o_qry_rvld = 0, starvation counter = 0; reset mid-RUN restarts full initialisation; in-flight responses discarded.

Configuration
REQ-032 Macro V_STATE_ARB_STARVE_EN defined: 4-bit counter increments each RUN cycle query requests and is denied; when counter = STARVE_N, query wins over update that cycle; counter clears on query grant or i_qry_ren = 0.
REQ-033 Macro undefined: strict update priority, no counter; query may starve indefinitely.

Verification
REQ-034 Reset release, CONTEXT_N=128 -> 128 consecutive zero writes addr 0..127, o_init_done rises cycle 129, no grants before.
REQ-035 RUN, upd reads addr 5 and qry reads addr 9 same cycle -> upd granted, upd_rvld next cycle with SRAM[5]; qry granted following cycle if upd idle.
REQ-036 RUN, upd writes 0xDEADBEEF to addr 3 while qry reads addr 3 (upd idle) -> qry_rvld next cycle, data 0xDEADBEEF.
REQ-037 STARVE_EN, STARVE_N=4, upd and qry request continuously -> query granted every 5th cycle; without macro, query never granted.
REQ-038 Assert rst mid-RUN with pending grant -> rvld outputs 0 next cycle, init sequence restarts at addr 0.

Source files
------------

// File: rtl/v_state_arb_if.sv
// Port bundle for v_state_arb: update/query read pipes, update write pipe, SRAM port and
// init status. The arbiter connects through slave; the requester/SRAM side uses master.
interface v_state_arb_if #(
  parameter int unsigned CONTEXT_N = 128,
  parameter int unsigned W         = 32
);
  localparam int unsigned ADDR_W = $clog2(CONTEXT_N);

  logic              i_upd_ren;
  logic [ADDR_W-1:0] i_upd_raddr;
  logic              o_upd_rgnt;
  logic              o_upd_rvld;
  logic [W-1:0]      o_upd_rdata;

  logic              i_qry_ren;
  logic [ADDR_W-1:0] i_qry_raddr;
  logic              o_qry_rgnt;
  logic              o_qry_rvld;
  logic [W-1:0]      o_qry_rdata;

  logic              i_upd_wen;
  logic [ADDR_W-1:0] i_upd_waddr;
  logic [W-1:0]      i_upd_wdata;

  logic              o_sram_ren;
  logic [ADDR_W-1:0] o_sram_raddr;
  logic [W-1:0]      i_sram_rdata;
  logic              o_sram_wen;
  logic [ADDR_W-1:0] o_sram_waddr;
  logic [W-1:0]      o_sram_wdata;

  logic              o_init_done;

  modport slave (
    input  i_upd_ren, i_upd_raddr, i_qry_ren, i_qry_raddr,
    input  i_upd_wen, i_upd_waddr, i_upd_wdata, i_sram_rdata,
    output o_upd_rgnt, o_upd_rvld, o_upd_rdata,
    output o_qry_rgnt, o_qry_rvld, o_qry_rdata,
    output o_sram_ren, o_sram_raddr, o_sram_wen, o_sram_waddr, o_sram_wdata,
    output o_init_done
  );

  modport master (
    output i_upd_ren, i_upd_raddr, i_qry_ren, i_qry_raddr,
    output i_upd_wen, i_upd_waddr, i_upd_wdata, i_sram_rdata,
    input  o_upd_rgnt, o_upd_rvld, o_upd_rdata,
    input  o_qry_rgnt, o_qry_rvld, o_qry_rdata,
    input  o_sram_ren, o_sram_raddr, o_sram_wen, o_sram_waddr, o_sram_wdata,
    input  o_init_done
  );
endinterface

// File: rtl/v_state_arb.sv
// State-table SRAM arbiter: zero-fills the table after reset, then arbitrates update/query reads
// (update first) with write-through bypass. V_STATE_ARB_STARVE_EN adds query anti-starvation.
module v_state_arb #(
  parameter int unsigned CONTEXT_N = 128,
  parameter int unsigned W         = 32,
  parameter int unsigned STARVE_N  = 4
) (
  input logic           clk,
  input logic           rst,
  v_state_arb_if.slave  bus
);
  localparam int unsigned ADDR_W = $clog2(CONTEXT_N);
  localparam logic [3:0] StarveLim = STARVE_N[3:0];
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(CONTEXT_N - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_done_q;
  logic              upd_gnt, qry_gnt, force_qry, bypass;
  logic              sram_wen;
  logic [ADDR_W-1:0] sram_waddr, sram_raddr;
  logic [W-1:0]      sram_wdata;
  logic              upd_rvld_q, qry_rvld_q, byp_q;
  logic [W-1:0]      byp_data_q, rsp_data;

`ifdef V_STATE_ARB_STARVE_EN
  logic [3:0] starve_q, starve_d;

  always_comb begin
    force_qry = (starve_q == StarveLim);
    starve_d  = starve_q;
    if (state_q == StRun) begin
      if (!bus.i_qry_ren || qry_gnt) begin
        starve_d = 4'd0;
      end else begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve;
  assign unused_starve = ^StarveLim;
  assign force_qry     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    upd_gnt    = 1'b0;
    qry_gnt    = 1'b0;
    sram_wen   = 1'b0;
    sram_waddr = init_cnt_q;
    sram_wdata = '0;
    unique case (state_q)
      StInit: begin
        sram_wen   = 1'b1;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LastAddr) begin
          state_d = StRun;
        end
      end
      StRun: begin
        sram_wen   = bus.i_upd_wen;
        sram_waddr = bus.i_upd_waddr;
        sram_wdata = bus.i_upd_wdata;
        upd_gnt    = bus.i_upd_ren & ~force_qry;
        qry_gnt    = bus.i_qry_ren & (~bus.i_upd_ren | force_qry);
      end
      default: state_d = StInit;
    endcase
    sram_raddr = upd_gnt ? bus.i_upd_raddr : bus.i_qry_raddr;
    // A same-cycle write to the read address wins over the stale SRAM word.
    bypass     = (upd_gnt | qry_gnt) & sram_wen & (state_q == StRun) & (sram_waddr == sram_raddr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      upd_rvld_q  <= 1'b0;
      qry_rvld_q  <= 1'b0;
      byp_q       <= 1'b0;
      byp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= (state_d == StRun);
      upd_rvld_q  <= upd_gnt;
      qry_rvld_q  <= qry_gnt;
      byp_q       <= bypass;
      byp_data_q  <= bus.i_upd_wdata;
    end
  end

  assign rsp_data = byp_q ? byp_data_q : bus.i_sram_rdata;

  assign bus.o_upd_rgnt   = upd_gnt;
  assign bus.o_qry_rgnt   = qry_gnt;
  assign bus.o_upd_rvld   = upd_rvld_q;
  assign bus.o_qry_rvld   = qry_rvld_q;
  assign bus.o_upd_rdata  = upd_rvld_q ? rsp_data : '0;
  assign bus.o_qry_rdata  = qry_rvld_q ? rsp_data : '0;
  assign bus.o_sram_ren   = upd_gnt | qry_gnt;
  assign bus.o_sram_raddr = sram_raddr;
  assign bus.o_sram_wen   = sram_wen;
  assign bus.o_sram_waddr = sram_waddr;
  assign bus.o_sram_wdata = sram_wdata;
  assign bus.o_init_done  = init_done_q;

endmodule

// File: tb/tb_v_state_arb.sv
// Bench for v_state_arb: SRAM model, init/reset sequences, vector table, directed corner cases
// and randomized traffic against a table-level reference model.
module tb_v_state_arb;
  localparam int unsigned CN = 128;
  localparam int unsigned DW = 32;
  localparam int unsigned SN = 4;
`ifdef V_STATE_ARB_STARVE_EN
  localparam bit StarveOn = 1'b1;
`else
  localparam bit StarveOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  v_state_arb_if #(.CONTEXT_N(CN), .W(DW)) bus ();

  v_state_arb #(.CONTEXT_N(CN), .W(DW), .STARVE_N(SN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // SRAM: registered read returns the pre-write word on a same-edge collision.
  logic [DW-1:0] sram [CN];
  always @(posedge clk) begin
    if (bus.o_sram_ren) bus.i_sram_rdata <= sram[bus.o_sram_raddr];
    if (bus.o_sram_wen) sram[bus.o_sram_waddr] <= bus.o_sram_wdata;
  end

  always @(posedge clk) begin
    if (!rst && !bus.o_init_done && bus.i_upd_wen) begin
      failures++;
      $display("FAIL init_write_protocol: i_upd_wen=1 while o_init_done=0");
    end
  end

  // Reference model: table contents, outstanding responses, query denial streak.
  logic [DW-1:0] ref_mem [CN];
  bit            pend_u, pend_q;
  logic [DW-1:0] pend_data;
  int            streak;
  bit            last_ug, last_qg;
  logic          obs_uv, obs_qv;
  logic [DW-1:0] obs_ud, obs_qd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CN; i++) ref_mem[i] = '0;
    pend_u = 0;
    pend_q = 0;
    pend_data = '0;
    streak = 0;
  endtask

  task automatic drive(input bit ur, input int ua, input bit qr, input int qa,
                       input bit we, input int wa, input logic [DW-1:0] wd);
    bus.i_upd_ren   = ur;
    bus.i_upd_raddr = 7'(ua);
    bus.i_qry_ren   = qr;
    bus.i_qry_raddr = 7'(qa);
    bus.i_upd_wen   = we;
    bus.i_upd_waddr = 7'(wa);
    bus.i_upd_wdata = wd;
  endtask

  // One RUN cycle: check against the model at the falling edge, then advance the model.
  task automatic cycle();
    bit exp_force, eu, eq;
    int ra;
    @(negedge clk);
    exp_force = StarveOn && (streak == SN);
    eu = bus.i_upd_ren && !exp_force;
    eq = bus.i_qry_ren && (!bus.i_upd_ren || exp_force);
    chk("init_done", 64'(bus.o_init_done), 64'd1);
    chk("upd_rgnt", 64'(bus.o_upd_rgnt), 64'(eu));
    chk("qry_rgnt", 64'(bus.o_qry_rgnt), 64'(eq));
    chk("sram_ren", 64'(bus.o_sram_ren), 64'(eu || eq));
    ra = eu ? int'(bus.i_upd_raddr) : int'(bus.i_qry_raddr);
    if (eu || eq) chk("sram_raddr", 64'(bus.o_sram_raddr), 64'(ra));
    chk("sram_wen", 64'(bus.o_sram_wen), 64'(bus.i_upd_wen));
    if (bus.i_upd_wen) begin
      chk("sram_waddr", 64'(bus.o_sram_waddr), 64'(bus.i_upd_waddr));
      chk("sram_wdata", 64'(bus.o_sram_wdata), 64'(bus.i_upd_wdata));
    end
    obs_uv = bus.o_upd_rvld;
    obs_qv = bus.o_qry_rvld;
    obs_ud = bus.o_upd_rdata;
    obs_qd = bus.o_qry_rdata;
    chk("upd_rvld", 64'(obs_uv), 64'(pend_u));
    chk("qry_rvld", 64'(obs_qv), 64'(pend_q));
    chk("upd_rdata", 64'(obs_ud), pend_u ? 64'(pend_data) : 64'd0);
    chk("qry_rdata", 64'(obs_qd), pend_q ? 64'(pend_data) : 64'd0);
    pend_u = eu;
    pend_q = eq;
    if (bus.i_upd_wen && int'(bus.i_upd_waddr) == ra) pend_data = bus.i_upd_wdata;
    else pend_data = ref_mem[ra];
    if (bus.i_upd_wen) ref_mem[bus.i_upd_waddr] = bus.i_upd_wdata;
    streak = (bus.i_qry_ren && !eq) ? streak + 1 : 0;
    last_ug = eu;
    last_qg = eq;
    @(posedge clk);
    #1;
  endtask

  // Full zero-fill after reset release; requests held high must not be granted.
  task automatic init_check();
    for (int i = 0; i < CN; i++) begin
      @(negedge clk);
      chk("init_wen", 64'(bus.o_sram_wen), 64'd1);
      chk("init_waddr", 64'(bus.o_sram_waddr), 64'(i));
      chk("init_wdata", 64'(bus.o_sram_wdata), 64'd0);
      chk("init_grants", {62'd0, bus.o_upd_rgnt, bus.o_qry_rgnt}, 64'd0);
      chk("init_sram_ren", 64'(bus.o_sram_ren), 64'd0);
      chk("init_done_low", 64'(bus.o_init_done), 64'd0);
      chk("init_rvld", {62'd0, bus.o_upd_rvld, bus.o_qry_rvld}, 64'd0);
      @(posedge clk);
      #1;
    end
    model_reset();
    drive(0, 0, 0, 0, 0, 0, '0);
  endtask

  typedef struct {
    bit ur; int ua; bit qr; int qa; bit we; int wa; logic [DW-1:0] wd; bit eu; bit eq;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [10];
    int qgrants;
    vecs[0] = '{1, 1, 0, 0, 0, 0, 32'h0,          1, 0};
    vecs[1] = '{0, 0, 1, 2, 1, 1, 32'h1111_0001,  0, 1};
    vecs[2] = '{1, 1, 1, 2, 0, 0, 32'h0,          1, 0};
    vecs[3] = '{0, 0, 1, 2, 0, 0, 32'h0,          0, 1};
    vecs[4] = '{0, 0, 1, 2, 1, 2, 32'hCAFE_0002,  0, 1};
    vecs[5] = '{1, 4, 0, 0, 1, 4, 32'hA5A5_0004,  1, 0};
    vecs[6] = '{1, 2, 1, 4, 1, 6, 32'h6666_0006,  1, 0};
    vecs[7] = '{1, 6, 1, 4, 0, 0, 32'h0,          1, 0};
    vecs[8] = '{0, 0, 1, 4, 0, 0, 32'h0,          0, 1};
    vecs[9] = '{0, 0, 0, 0, 1, 1, 32'h7777_0001,  0, 0};

    drive(1, 0, 1, 0, 0, 0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    init_check();

    foreach (vecs[i]) begin
      drive(vecs[i].ur, vecs[i].ua, vecs[i].qr, vecs[i].qa, vecs[i].we, vecs[i].wa, vecs[i].wd);
      cycle();
      chk($sformatf("vec%0d_ugnt", i), 64'(last_ug), 64'(vecs[i].eu));
      chk($sformatf("vec%0d_qgnt", i), 64'(last_qg), 64'(vecs[i].eq));
    end
    drive(0, 0, 0, 0, 0, 0, '0);
    cycle();

    // Update beats query; query follows once update goes idle.
    drive(0, 0, 0, 0, 1, 5, 32'h0000_0055); cycle();
    drive(0, 0, 0, 0, 1, 9, 32'h0000_0099); cycle();
    drive(1, 5, 1, 9, 0, 0, '0); cycle();
    chk("r035_ugnt", 64'(last_ug), 64'd1);
    drive(0, 0, 1, 9, 0, 0, '0); cycle();
    chk("r035_qgnt", 64'(last_qg), 64'd1);
    chk("r035_udata", {31'd0, obs_uv, obs_ud}, {31'd0, 1'b1, 32'h0000_0055});
    drive(0, 0, 0, 0, 0, 0, '0); cycle();
    chk("r035_qdata", {31'd0, obs_qv, obs_qd}, {31'd0, 1'b1, 32'h0000_0099});

    // Write-to-read bypass on the query pipe.
    drive(0, 0, 1, 3, 1, 3, 32'hDEAD_BEEF); cycle();
    drive(0, 0, 0, 0, 0, 0, '0); cycle();
    chk("r036_bypass", {31'd0, obs_qv, obs_qd}, {31'd0, 1'b1, 32'hDEAD_BEEF});

    // Both pipes requesting continuously.
    qgrants = 0;
    drive(1, 10, 1, 11, 0, 0, '0);
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (last_qg) qgrants++;
    end
    chk("r037_qry_grants", 64'(qgrants), StarveOn ? 64'd4 : 64'd0);
    drive(0, 0, 0, 0, 0, 0, '0);
    cycle();

    // Randomized traffic honouring the hold-until-granted rule.
    for (int c = 0; c < 1500; c++) begin
      if (!(bus.i_upd_ren && !last_ug)) begin
        bus.i_upd_ren   = ($urandom_range(1, 0) == 1);
        bus.i_upd_raddr = 7'($urandom_range(7, 0));
      end
      if (!(bus.i_qry_ren && !last_qg)) begin
        bus.i_qry_ren   = ($urandom_range(1, 0) == 1);
        bus.i_qry_raddr = 7'($urandom_range(7, 0));
      end
      bus.i_upd_wen   = ($urandom_range(9, 0) < 3);
      bus.i_upd_waddr = 7'($urandom_range(7, 0));
      bus.i_upd_wdata = $urandom;
      cycle();
    end

    // Reset with a response in flight discards it and restarts initialisation.
    drive(1, 7, 0, 0, 0, 0, '0);
    cycle();
    chk("r038_pre_ugnt", 64'(last_ug), 64'd1);
    rst = 1'b1;
    #1;
    chk("r038_rvld_cleared", {62'd0, bus.o_upd_rvld, bus.o_qry_rvld}, 64'd0);
    chk("r038_done_cleared", 64'(bus.o_init_done), 64'd0);
    drive(1, 7, 1, 8, 0, 0, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    init_check();
    drive(1, 3, 0, 0, 0, 0, '0); cycle();
    drive(0, 0, 0, 0, 0, 0, '0); cycle();
    chk("r038_table_zeroed", {31'd0, obs_uv, obs_ud}, {31'd0, 1'b1, 32'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
